// File: rtl/handshake_rr_merge_pkg.sv
// handshake_rr_merge_pkg: default sizes and shared types for the round-robin merge
package handshake_rr_merge_pkg;
  localparam int DEF_N_PORTS = 3;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
  typedef logic [$clog2(DEF_N_PORTS)-1:0] src_idx_t;
  typedef logic [DEF_WIDTH-1:0] payload_t;
endpackage

// File: rtl/handshake_rr_merge_rr_arbiter.sv
// rr_arbiter: round-robin grant over req starting at ptr (clk, rst, req, advance -> grant one-hot, idx, ptr)
module rr_arbiter
  import handshake_rr_merge_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  localparam int IW = $clog2(N_PORTS)
) (
  input  logic clk,
  input  logic rst,
  input  logic [N_PORTS-1:0] req,
  input  logic advance,
  output logic [N_PORTS-1:0] grant,
  output logic [IW-1:0] idx,
  output logic [IW-1:0] ptr
);
  logic [IW-1:0] cand;
  logic found;
  always_comb begin
    grant = '0;
    idx = '0;
    cand = '0;
    found = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      cand = IW'((int'(ptr) + k) % N_PORTS);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx = cand;
        grant[cand] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (advance) ptr <= (idx == IW'(N_PORTS - 1)) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/handshake_rr_merge.sv
// handshake_rr_merge: round-robin merge of N ready/valid producers into one registered channel (CLK, RESET, in_valid/in_ready/in_data -> out_valid/out_ready/out_data/out_src, xfer_count); HANDSHAKE_RR_MERGE_SVA_EN adds assertions
module handshake_rr_merge
  import handshake_rr_merge_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  localparam int IW = $clog2(N_PORTS)
) (
  input  logic CLK,
  input  logic RESET,
  input  logic [N_PORTS-1:0] in_valid,
  output logic [N_PORTS-1:0] in_ready,
  input  logic [WIDTH-1:0] in_data [N_PORTS-1:0],
  output logic out_valid,
  input  logic out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IW-1:0] out_src,
  output logic [CNT_W-1:0] xfer_count
);
  logic load, any;
  logic [N_PORTS-1:0] grant;
  logic [IW-1:0] idx, ptr;
  assign load = !out_valid || out_ready;
  assign any = |grant;
  assign in_ready = (load && !RESET) ? grant : '0;
  rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
    .clk(CLK),
    .rst(RESET),
    .req(in_valid),
    .advance(load && any),
    .grant(grant),
    .idx(idx),
    .ptr(ptr)
  );
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
      xfer_count <= '0;
    end else begin
      if (out_valid && out_ready && xfer_count != '1) xfer_count <= xfer_count + 1'b1;
      if (load) begin
        out_valid <= any;
        if (any) begin
          out_data <= in_data[idx];
          out_src <= idx;
        end
      end
    end
  end
`ifdef HANDSHAKE_RR_MERGE_SVA_EN
  logic [N_PORTS*N_PORTS-1:0] hist;
  logic [N_PORTS-1:0] seen;
  always_ff @(posedge CLK) hist <= RESET ? '0 : {hist[N_PORTS*(N_PORTS-1)-1:0], in_ready};
  always_comb begin
    seen = '0;
    for (int k = 0; k < N_PORTS; k++) seen = seen | hist[k*N_PORTS +: N_PORTS];
  end
  a_onehot: assert property (@(posedge CLK) disable iff (RESET) $onehot0(in_ready));
  a_hold: assert property (@(posedge CLK) disable iff (RESET)
    out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_src));
  a_cnt: assert property (@(posedge CLK) disable iff (RESET)
    !$past(RESET) |-> xfer_count >= $past(xfer_count));
  for (genvar i = 0; i < N_PORTS; i++) begin : g_rv
    a_rv: assert property (@(posedge CLK) disable iff (RESET) in_ready[i] |-> in_valid[i]);
  end
  c_all: cover property (@(posedge CLK) disable iff (RESET) &seen);
`else
`endif
endmodule

// File: tb/tb_handshake_rr_merge.sv
// tb_handshake_rr_merge: directed plus random stimulus against a behavioural merge model
module tb_handshake_rr_merge;
  import handshake_rr_merge_pkg::*;
  localparam int N = DEF_N_PORTS;
  logic CLK, RESET, out_ready, out_valid, s_valid;
  logic [N-1:0] in_valid, in_ready, s_ready;
  payload_t in_data [N-1:0];
  payload_t out_data, s_data;
  src_idx_t out_src, s_src;
  logic [DEF_CNT_W-1:0] xfer_count;
  logic [2:0] s_count;
  int n_tests = 0, n_fail = 0;
  int m_ptr, m_src, m_cnt, m_cnt3;
  logic m_valid;
  payload_t m_data;
  handshake_rr_merge dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .xfer_count(xfer_count)
  );
  handshake_rr_merge #(.CNT_W(3)) dut_sat (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(s_ready), .in_data(in_data),
    .out_valid(s_valid), .out_ready(out_ready), .out_data(s_data), .out_src(s_src),
    .xfer_count(s_count)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic [N-1:0] v, input payload_t d0, d1, d2, input logic o);
    int win;
    logic [N-1:0] exp_rdy;
    @(negedge CLK);
    RESET = r;
    in_valid = v;
    in_data[0] = d0;
    in_data[1] = d1;
    in_data[2] = d2;
    out_ready = o;
    #1;
    win = -1;
    for (int k = N - 1; k >= 0; k--) if (v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    exp_rdy = (!r && (!m_valid || o) && win >= 0) ? N'(1 << win) : '0;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("sat_in_ready", 32'(s_ready), 32'(exp_rdy));
    if (r) begin
      m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0; m_cnt = 0; m_cnt3 = 0;
    end else begin
      if (m_valid && o) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_cnt3 = (m_cnt3 < 7) ? m_cnt3 + 1 : 7;
      end
      if (!m_valid || o) begin
        m_valid = (win >= 0);
        if (win >= 0) begin
          m_data = in_data[win];
          m_src = win;
          m_ptr = (win + 1) % N;
        end
      end
    end
    @(posedge CLK);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_src", 32'(out_src), 32'(m_src));
    chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
    chk("sat_count", 32'(s_count), 32'(m_cnt3));
  endtask
  initial begin
    RESET = 1'b1; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) in_data[i] = '0;
    m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0; m_cnt = 0; m_cnt3 = 0;
    cyc(1, 3'b000, 0, 0, 0, 0);
    cyc(1, 3'b000, 0, 0, 0, 0);
    cyc(0, 3'b000, 0, 0, 0, 1);
    cyc(1, 3'b000, 0, 0, 0, 1);
    cyc(0, 3'b010, 0, 4'hA, 0, 1);
    cyc(0, 3'b000, 0, 0, 0, 1);
    cyc(0, 3'b000, 0, 0, 0, 1);
    cyc(1, 3'b000, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) cyc(0, 3'b111, 1, 2, 3, 1);
    cyc(0, 3'b111, 5, 5, 5, 0);
    for (int i = 0; i < 4; i++) cyc(0, 3'b111, 6, 7, 8, 0);
    for (int i = 0; i < 3; i++) cyc(0, 3'b111, 6, 7, 8, 1);
    for (int i = 0; i < 10; i++) cyc(0, 3'b111, 4'(i), 4'(i + 1), 4'(i + 2), 1);
    cyc(0, 3'b111, 9, 9, 9, 0);
    cyc(1, 3'b111, 9, 9, 9, 0);
    cyc(0, 3'b110, 1, 2, 3, 1);
    cyc(0, 3'b110, 1, 2, 3, 1);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 59) == 0, N'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
          4'($urandom), $urandom_range(0, 3) != 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
